// File: rtl/alu_pipe_if.sv
// Request/response bundle for alu_pipe: valid/ready request side, valid/ready result side.
// The master drives requests and consumes results; the slave is the ALU.
interface alu_pipe_if #(
  parameter int WORD_SIZE = 16
) ();
  logic                 alu_enable;
  logic                 alu_ready;
  logic [4:0]           opcode;
  logic [WORD_SIZE-1:0] input1;
  logic [WORD_SIZE-1:0] input2;
  logic [WORD_SIZE-1:0] alu_out;
  logic                 alu_valid;
  logic                 out_ready;
  logic [3:0]           flags;
  logic                 illegal_op;
  logic                 busy;

  modport master (
    output alu_enable, opcode, input1, input2, out_ready,
    input  alu_ready, alu_out, alu_valid, flags, illegal_op, busy
  );

  modport slave (
    input  alu_enable, opcode, input1, input2, out_ready,
    output alu_ready, alu_out, alu_valid, flags, illegal_op, busy
  );
endinterface

// File: rtl/alu_pipe.sv
// Handshaked ALU stage with a registered result/flags slot and either an
// iterative (1 bit/cycle) or barrel shifter chosen at elaboration.
module alu_pipe #(
  parameter int         WORD_SIZE  = 16,
  parameter int         ITER_SHIFT = 1,
  parameter logic [4:0] OP_NOT     = 5'd0,
  parameter logic [4:0] OP_AND     = 5'd1,
  parameter logic [4:0] OP_ANDI    = 5'd2,
  parameter logic [4:0] OP_OR      = 5'd3,
  parameter logic [4:0] OP_XOR     = 5'd4,
  parameter logic [4:0] OP_ADD     = 5'd5,
  parameter logic [4:0] OP_ADDI    = 5'd6,
  parameter logic [4:0] OP_SUB     = 5'd7,
  parameter logic [4:0] OP_COMP    = 5'd8,
  parameter logic [4:0] OP_SRI     = 5'd9,
  parameter logic [4:0] OP_SLI     = 5'd10
) (
  input logic       clock,
  input logic       reset_n,
  alu_pipe_if.slave bus
);
  localparam int                   MSB     = WORD_SIZE - 1;
  localparam int                   CW      = $clog2(WORD_SIZE + 1);
  localparam logic [CW-1:0]        CNT_ONE = CW'(1);
  localparam logic [WORD_SIZE-1:0] WS_VAL  = WORD_SIZE'(WORD_SIZE);

  typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  typedef struct packed {
    logic [WORD_SIZE-1:0] res;
    logic                 c;
    logic                 v;
    logic                 ill;
  } alu_res_t;

  state_t               state_r, state_next_s;
  logic [WORD_SIZE-1:0] shift_a_r, step_a_s, alu_out_r, wr_res_s;
  logic [CW-1:0]        cnt_r, amt_s;
  logic                 shift_left_r, step_c_s;
  logic                 alu_valid_r, illegal_op_r, wr_ill_s, write_s;
  logic [3:0]           flags_r, wr_flags_s;
  logic                 alu_ready_s, accept_s, is_shift_s, start_iter_s;
  alu_res_t             comp_s;

  function automatic logic [CW-1:0] clamp_amt(input logic [WORD_SIZE-1:0] b);
    if (b >= WS_VAL) return CW'(WORD_SIZE);
    else             return b[CW-1:0];
  endfunction

  function automatic logic [3:0] make_flags(input logic [WORD_SIZE-1:0] res,
                                            input logic c, input logic v);
    return {(res == {WORD_SIZE{1'b0}}), res[MSB], c, v};
  endfunction

  function automatic alu_res_t compute(input logic [4:0] op,
                                       input logic [WORD_SIZE-1:0] a,
                                       input logic [WORD_SIZE-1:0] b);
    alu_res_t                 r;
    logic [WORD_SIZE:0]       sum;
    logic [2*WORD_SIZE-1:0]   wide;
    logic [CW-1:0]            amt;
    r    = '{res: {WORD_SIZE{1'b0}}, c: 1'b0, v: 1'b0, ill: 1'b0};
    sum  = {(WORD_SIZE+1){1'b0}};
    wide = {(2*WORD_SIZE){1'b0}};
    amt  = clamp_amt(b);
    case (op)
      OP_NOT:          r.res = ~a;
      OP_AND, OP_ANDI: r.res = a & b;
      OP_OR:           r.res = a | b;
      OP_XOR:          r.res = a ^ b;
      OP_ADD, OP_ADDI: begin
        sum   = {1'b0, a} + {1'b0, b};
        r.res = sum[MSB:0];
        r.c   = sum[WORD_SIZE];
        r.v   = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      OP_SUB: begin
        sum   = {1'b0, a} - {1'b0, b};
        r.res = sum[MSB:0];
        r.c   = sum[WORD_SIZE];
        r.v   = (a[MSB] != b[MSB]) && (sum[MSB] != a[MSB]);
      end
      OP_COMP: r.res = (a == b) ? {{(WORD_SIZE-1){1'b0}}, 1'b1} : {WORD_SIZE{1'b0}};
      // Shift through a double-width window so the bit just past the result is the carry.
      OP_SRI: begin
        wide  = {a, {WORD_SIZE{1'b0}}} >> amt;
        r.res = wide[2*WORD_SIZE-1:WORD_SIZE];
        r.c   = wide[MSB];
      end
      OP_SLI: begin
        wide  = {{WORD_SIZE{1'b0}}, a} << amt;
        r.res = wide[MSB:0];
        r.c   = wide[WORD_SIZE];
      end
      default: r.ill = 1'b1;
    endcase
    return r;
  endfunction

  assign alu_ready_s  = (state_r == IDLE) && (!alu_valid_r || bus.out_ready);
  assign accept_s     = bus.alu_enable && alu_ready_s;
  assign is_shift_s   = (bus.opcode == OP_SRI) || (bus.opcode == OP_SLI);
  assign amt_s        = clamp_amt(bus.input2);
  assign start_iter_s = (ITER_SHIFT != 0) && accept_s && is_shift_s && (amt_s != {CW{1'b0}});
  assign comp_s       = compute(bus.opcode, bus.input1, bus.input2);
  assign step_a_s     = shift_left_r ? {shift_a_r[MSB-1:0], 1'b0} : {1'b0, shift_a_r[MSB:1]};
  assign step_c_s     = shift_left_r ? shift_a_r[MSB] : shift_a_r[0];

  // FSM state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_r <= IDLE;
    else          state_r <= state_next_s;
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_iter_s) state_next_s = SHIFT;
        else              state_next_s = IDLE;
      end
      SHIFT: begin
        if (cnt_r == CNT_ONE) state_next_s = IDLE;
        else                  state_next_s = SHIFT;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Select what, if anything, is written into the result slot this edge
  always_comb begin
    write_s    = 1'b0;
    wr_res_s   = comp_s.res;
    wr_flags_s = make_flags(comp_s.res, comp_s.c, comp_s.v);
    wr_ill_s   = comp_s.ill;
    if ((state_r == SHIFT) && (cnt_r == CNT_ONE)) begin
      write_s    = 1'b1;
      wr_res_s   = step_a_s;
      wr_flags_s = make_flags(step_a_s, step_c_s, 1'b0);
      wr_ill_s   = 1'b0;
    end else if (accept_s && !start_iter_s) begin
      write_s = 1'b1;
    end else begin
      write_s = 1'b0;
    end
  end

  // Result slot: a fresh write wins over consumption so back-to-back ops flow at 1/cycle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      alu_out_r    <= {WORD_SIZE{1'b0}};
      flags_r      <= 4'b0000;
      illegal_op_r <= 1'b0;
      alu_valid_r  <= 1'b0;
    end else if (write_s) begin
      alu_out_r    <= wr_res_s;
      flags_r      <= wr_flags_s;
      illegal_op_r <= wr_ill_s;
      alu_valid_r  <= 1'b1;
    end else if (bus.out_ready) begin
      alu_valid_r  <= 1'b0;
    end else begin
      alu_valid_r  <= alu_valid_r;
    end
  end

  // Iterative shifter operand and step counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shift_a_r    <= {WORD_SIZE{1'b0}};
      cnt_r        <= {CW{1'b0}};
      shift_left_r <= 1'b0;
    end else if (start_iter_s) begin
      shift_a_r    <= bus.input1;
      cnt_r        <= amt_s;
      shift_left_r <= (bus.opcode == OP_SLI);
    end else if (state_r == SHIFT) begin
      shift_a_r    <= step_a_s;
      cnt_r        <= cnt_r - CNT_ONE;
    end else begin
      cnt_r        <= cnt_r;
    end
  end

  assign bus.alu_ready  = alu_ready_s;
  assign bus.alu_out    = alu_out_r;
  assign bus.flags      = flags_r;
  assign bus.illegal_op = illegal_op_r;
  assign bus.alu_valid  = alu_valid_r;
  assign bus.busy       = (ITER_SHIFT != 0) && (state_r == SHIFT);
endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WORD_SIZE=16, ITER_SHIFT=1) with a plain-arithmetic reference model.
module tb_alu_pipe;
  localparam logic [4:0] NOT_ = 5'd0, AND_ = 5'd1, ANDI = 5'd2, OR_ = 5'd3, XOR_ = 5'd4, ADD_ = 5'd5;
  localparam logic [4:0] ADDI = 5'd6, SUB_ = 5'd7, COMP = 5'd8, SRI_ = 5'd9, SLI_ = 5'd10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  alu_pipe_if #(.WORD_SIZE(16)) bus ();

  alu_pipe #(
    .WORD_SIZE(16), .ITER_SHIFT(1),
    .OP_NOT(NOT_), .OP_AND(AND_), .OP_ANDI(ANDI), .OP_OR(OR_), .OP_XOR(XOR_), .OP_ADD(ADD_),
    .OP_ADDI(ADDI), .OP_SUB(SUB_), .OP_COMP(COMP), .OP_SRI(SRI_), .OP_SLI(SLI_)
  ) dut (.clock(clk), .reset_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // Reference: results from integer arithmetic, latency from the op description
  function automatic void model(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] r, output logic [3:0] f, output logic ill,
                                output int lat);
    longint ua, ub, s;
    int amt;
    logic c, v;
    ua = longint'(a); ub = longint'(b);
    amt = (ub > 16) ? 16 : int'(ub);
    c = 1'b0; v = 1'b0; ill = 1'b0; lat = 1; r = 16'h0000;
    if (op == NOT_) r = 16'(65535 - ua);
    else if (op == AND_ || op == ANDI) r = a & b;
    else if (op == OR_) r = a | b;
    else if (op == XOR_) r = a ^ b;
    else if (op == ADD_ || op == ADDI) begin
      s = ua + ub; r = 16'(s % 65536); c = (s > 65535);
      s = longint'($signed(a)) + longint'($signed(b)); v = (s > 32767) || (s < -32768);
    end else if (op == SUB_) begin
      s = ua - ub + 65536; r = 16'(s % 65536); c = (ua < ub);
      s = longint'($signed(a)) - longint'($signed(b)); v = (s > 32767) || (s < -32768);
    end else if (op == COMP) r = (a == b) ? 16'd1 : 16'd0;
    else if (op == SLI_) begin
      s = ua * (longint'(1) << amt); r = 16'(s % 65536); c = (amt > 0) && (((s / 65536) % 2) == 1);
      lat = amt + 1;
    end else if (op == SRI_) begin
      r = 16'(ua / (longint'(1) << amt));
      c = (amt > 0) && (((ua / (longint'(1) << (amt - 1))) % 2) == 1);
      lat = amt + 1;
    end else ill = 1'b1;
    f = {(r == 16'h0000), r[15], c, v};
  endfunction

  // Issue one op with out_ready=1 and report what came back and how long it took
  task automatic run_op(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] r, output logic [3:0] f, output logic ill,
                        output int lat, output int busy_n, output bit timeout);
    int guard;
    guard = 0; lat = 0; busy_n = 0;
    @(negedge clk);
    bus.out_ready = 1'b1;
    #1;
    while (!bus.alu_ready && guard < 50) begin @(negedge clk); #1; guard++; end
    bus.alu_enable = 1'b1; bus.opcode = op; bus.input1 = a; bus.input2 = b;
    @(posedge clk); #1;
    bus.alu_enable = 1'b0; bus.opcode = 5'($urandom); bus.input1 = 16'($urandom); bus.input2 = 16'($urandom);
    while (lat < 60) begin
      @(negedge clk); lat++;
      if (bus.busy && !bus.alu_ready) busy_n++;
      if (bus.alu_valid) break;
    end
    timeout = !bus.alu_valid;
    r = bus.alu_out; f = bus.flags; ill = bus.illegal_op;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({bus.alu_out, bus.flags, bus.alu_valid, bus.illegal_op, bus.busy, bus.alu_ready} !== {16'h0, 4'h0, 4'b0001}) begin
      errors++; $display("FAIL reset_state got out=%h fl=%b v=%b ill=%b busy=%b rdy=%b required 0000/0000/0/0/0/1",
                         bus.alu_out, bus.flags, bus.alu_valid, bus.illegal_op, bus.busy, bus.alu_ready);
    end
  endtask

  task automatic test_directed();
    logic [4:0]  ops [5] = '{ADD_, ADD_, SUB_, COMP, NOT_};
    logic [15:0] as  [5] = '{16'hFFFF, 16'h7FFF, 16'h0003, 16'h1234, 16'h00FF};
    logic [15:0] bs  [5] = '{16'h0001, 16'h0001, 16'h0005, 16'h1234, 16'h0000};
    logic [15:0] xr  [5] = '{16'h0000, 16'h8000, 16'hFFFE, 16'h0001, 16'hFF00};
    logic [3:0]  xf  [5] = '{4'b1010, 4'b0101, 4'b0110, 4'b0000, 4'b0100};
    logic [15:0] r; logic [3:0] f; logic ill; int lat, bn; bit to;
    for (int i = 0; i < 5; i++) begin
      run_op(ops[i], as[i], bs[i], r, f, ill, lat, bn, to);
      checks++;
      if ({r, f, ill, to} !== {xr[i], xf[i], 1'b0, 1'b0} || lat != 1) begin
        errors++; $display("FAIL directed_%0d got out=%h fl=%b ill=%b lat=%0d required out=%h fl=%b ill=0 lat=1",
                           i, r, f, ill, lat, xr[i], xf[i]);
      end
    end
  endtask

  task automatic test_shift_iter();
    logic [4:0]  ops [4] = '{SLI_, SRI_, SRI_, SLI_};
    logic [15:0] as  [4] = '{16'h8001, 16'h0001, 16'h8000, 16'hA5A5};
    logic [15:0] bs  [4] = '{16'd4, 16'd20, 16'd16, 16'd0};
    logic [15:0] xr  [4] = '{16'h0010, 16'h0000, 16'h0000, 16'hA5A5};
    logic [3:0]  xf  [4] = '{4'b0000, 4'b1000, 4'b1010, 4'b0100};
    int          xl  [4] = '{5, 17, 17, 1};
    logic [15:0] r; logic [3:0] f; logic ill; int lat, bn; bit to;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], as[i], bs[i], r, f, ill, lat, bn, to);
      checks++;
      if ({r, f, ill, to} !== {xr[i], xf[i], 1'b0, 1'b0} || lat != xl[i] || bn != xl[i] - 1) begin
        errors++; $display("FAIL shift_%0d got out=%h fl=%b lat=%0d busy=%0d required out=%h fl=%b lat=%0d busy=%0d",
                           i, r, f, lat, bn, xr[i], xf[i], xl[i], xl[i] - 1);
      end
    end
  endtask

  task automatic test_random();
    logic [4:0]  all_ops [11] = '{NOT_, AND_, ANDI, OR_, XOR_, ADD_, ADDI, SUB_, COMP, SRI_, SLI_};
    logic [15:0] corner  [4]  = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000};
    logic [4:0]  op; logic [15:0] a, b, r, er; logic [3:0] f, ef; logic ill, eill;
    int lat, el, bn; bit to;
    for (int i = 0; i < 60; i++) begin
      op = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(11, 31)) : all_ops[$urandom_range(0, 10)];
      a  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : 16'($urandom);
      b  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : 16'($urandom);
      if (op == SRI_ || op == SLI_) b = 16'($urandom_range(0, 20));
      model(op, a, b, er, ef, eill, el);
      run_op(op, a, b, r, f, ill, lat, bn, to);
      checks++;
      if ({r, f, ill, to} !== {er, ef, eill, 1'b0} || lat != el) begin
        errors++; $display("FAIL random_%0d op=%h a=%h b=%h got out=%h fl=%b ill=%b lat=%0d required out=%h fl=%b ill=%b lat=%0d",
                           i, op, a, b, r, f, ill, lat, er, ef, eill, el);
      end
    end
  endtask

  task automatic test_back_pressure();
    logic [15:0] a1, b1, a2, b2, er, er2; logic [3:0] ef, ef2; logic eill; int el;
    a1 = 16'($urandom); b1 = 16'($urandom); a2 = 16'($urandom); b2 = 16'($urandom);
    model(ADD_, a1, b1, er, ef, eill, el);
    model(XOR_, a2, b2, er2, ef2, eill, el);
    @(negedge clk);
    bus.out_ready = 1'b0; bus.alu_enable = 1'b1; bus.opcode = ADD_; bus.input1 = a1; bus.input2 = b1;
    @(posedge clk); #1;
    bus.opcode = XOR_; bus.input1 = a2; bus.input2 = b2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.alu_ready, bus.alu_valid, bus.alu_out, bus.flags} !== {1'b0, 1'b1, er, ef}) begin
        errors++; $display("FAIL stall_%0d got rdy=%b v=%b out=%h fl=%b required rdy=0 v=1 out=%h fl=%b",
                           i, bus.alu_ready, bus.alu_valid, bus.alu_out, bus.flags, er, ef);
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.alu_enable = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.alu_valid, bus.alu_out, bus.flags} !== {1'b1, er2, ef2}) begin
      errors++; $display("FAIL release got v=%b out=%h fl=%b required v=1 out=%h fl=%b",
                         bus.alu_valid, bus.alu_out, bus.flags, er2, ef2);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  ops [9] = '{NOT_, AND_, ANDI, OR_, XOR_, ADD_, ADDI, SUB_, COMP};
    logic [15:0] qr[$]; logic [3:0] qf[$];
    logic [15:0] a, b, er; logic [3:0] ef; logic eill; logic [4:0] op; int el;
    @(negedge clk);
    bus.out_ready = 1'b1;
    for (int i = 0; i <= 12; i++) begin
      if (i > 0) begin
        er = qr.pop_front(); ef = qf.pop_front();
        checks++;
        if ({bus.alu_valid, bus.alu_out, bus.flags} !== {1'b1, er, ef}) begin
          errors++; $display("FAIL b2b_%0d got v=%b out=%h fl=%b required v=1 out=%h fl=%b",
                             i, bus.alu_valid, bus.alu_out, bus.flags, er, ef);
        end
      end
      if (i < 12) begin
        op = ops[$urandom_range(0, 8)]; a = 16'($urandom); b = 16'($urandom);
        model(op, a, b, er, ef, eill, el);
        qr.push_back(er); qf.push_back(ef);
        bus.alu_enable = 1'b1; bus.opcode = op; bus.input1 = a; bus.input2 = b;
      end else bus.alu_enable = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_shift();
    logic [15:0] r; logic [3:0] f; logic ill; int lat, bn, vcount; bit to;
    @(negedge clk);
    bus.out_ready = 1'b1; bus.alu_enable = 1'b1; bus.opcode = SLI_; bus.input1 = 16'h00F3; bus.input2 = 16'd10;
    @(posedge clk); #1;
    bus.alu_enable = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.alu_out, bus.flags, bus.alu_valid, bus.illegal_op, bus.busy} !== 23'h0) begin
      errors++; $display("FAIL reset_mid_shift got out=%h fl=%b v=%b ill=%b busy=%b required all 0",
                         bus.alu_out, bus.flags, bus.alu_valid, bus.illegal_op, bus.busy);
    end
    @(negedge clk); rst_n = 1'b1;
    vcount = 0;
    repeat (15) begin @(negedge clk); if (bus.alu_valid || bus.busy) vcount++; end
    checks++;
    if (vcount != 0) begin
      errors++; $display("FAIL stale_after_reset got %0d active cycles required 0", vcount);
    end
    run_op(5'h1F, 16'($urandom), 16'($urandom), r, f, ill, lat, bn, to);
    checks++;
    if ({r, f, ill, to} !== {16'h0000, 4'b1000, 1'b1, 1'b0} || lat != 1) begin
      errors++; $display("FAIL illegal_op got out=%h fl=%b ill=%b lat=%0d required out=0000 fl=1000 ill=1 lat=1",
                         r, f, ill, lat);
    end
  endtask

  initial begin
    bus.alu_enable = 1'b0; bus.opcode = 5'd0; bus.input1 = 16'h0; bus.input2 = 16'h0; bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_directed();
    test_shift_iter();
    test_random();
    test_back_pressure();
    test_back_to_back();
    test_reset_mid_shift();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
